// File: rtl/mic_volume_meter.sv
// Microphone loudness meter: samples mic_in every SAMPLE_DIV clocks, tracks peak deviation
// from mid-scale over WINDOW samples and publishes a 4-bit level at the end of each window.
module mic_volume_meter #(
    parameter int unsigned SAMPLE_DIV = 5000,
    parameter int unsigned WINDOW     = 4000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [11:0] mic_in,
    output logic [3:0]  vol,
    output logic        vol_valid,
    output logic        sample_tick
);

    localparam int unsigned DivW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned WinW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(SAMPLE_DIV - 1);
    localparam logic [WinW-1:0] WinLast = WinW'(WINDOW - 1);

    logic [DivW-1:0] r_div_cnt;
    logic [WinW-1:0] r_win_cnt;
    logic [10:0]     r_peak;
    logic [11:0]     r_sample;
    logic            r_s_valid;
    logic [3:0]      r_vol;
    logic            r_vol_valid;

    logic [11:0]     w_neg_diff;
    logic [10:0]     w_mag;
    logic [10:0]     w_cand;

    // Below mid-scale, only sample 0 yields 2048, which saturates to 2047.
    always_comb begin
        w_neg_diff = 12'd2048 - r_sample;
        if (r_sample[11]) begin
            w_mag = r_sample[10:0];
        end else if (w_neg_diff[11]) begin
            w_mag = 11'd2047;
        end else begin
            w_mag = w_neg_diff[10:0];
        end
        w_cand = (w_mag > r_peak) ? w_mag : r_peak;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_div_cnt <= '0;
            r_sample  <= '0;
            r_s_valid <= 1'b0;
        end else begin
            r_s_valid <= 1'b0;
            if (r_div_cnt == DivLast) begin
                r_div_cnt <= '0;
                r_sample  <= mic_in;
                r_s_valid <= 1'b1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_win_cnt   <= '0;
            r_peak      <= '0;
            r_vol       <= '0;
            r_vol_valid <= 1'b0;
        end else begin
            r_vol_valid <= 1'b0;
            if (r_s_valid) begin
                if (r_win_cnt == WinLast) begin
                    // The window's final sample is folded into this window's result.
                    r_vol       <= w_cand[10:7];
                    r_vol_valid <= 1'b1;
                    r_peak      <= '0;
                    r_win_cnt   <= '0;
                end else begin
                    r_peak    <= w_cand;
                    r_win_cnt <= r_win_cnt + 1'b1;
                end
            end
        end
    end

    assign vol         = r_vol;
    assign vol_valid   = r_vol_valid;
    assign sample_tick = r_s_valid;

endmodule

// File: tb/tb_mic_volume_meter.sv
// Scoreboard bench for mic_volume_meter with SAMPLE_DIV = 4, WINDOW = 8.
module tb_mic_volume_meter;

    localparam int Div = 4;
    localparam int Win = 8;

    logic        clk;
    logic        clr;
    logic [11:0] mic_in;
    logic [3:0]  vol;
    logic        vol_valid;
    logic        sample_tick;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;
    int q_vol[$];
    int q_cyc[$];

    mic_volume_meter #(
        .SAMPLE_DIV (Div),
        .WINDOW     (Win)
    ) u_dut (
        .clk         (clk),
        .clr         (clr),
        .mic_in      (mic_in),
        .vol         (vol),
        .vol_valid   (vol_valid),
        .sample_tick (sample_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since clr release; the DUT divider should equal cyc % Div.
    always @(posedge clk or posedge clr) begin
        if (clr) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_mag(input int s);
        int d;
        d = s - 2048;
        if (d < 0) d = -d;
        if (d > 2047) d = 2047;
        return d;
    endfunction

    // Drives n captures: base everywhere except loud at capture index pos.
    // mic_in is scrambled after every capture to show between-capture values are ignored.
    task automatic run_samples(input int base, input int loud, input int pos, input int n,
                               input bit push);
        int peak;
        int s;
        peak = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            while (cyc % Div != Div - 1) @(negedge clk);
            s = (i == pos) ? loud : base;
            mic_in = 12'(s);
            if (ref_mag(s) > peak) peak = ref_mag(s);
            @(posedge clk);
            #1;
            if (push && i == n - 1) begin
                q_vol.push_back(peak / 128);
                q_cyc.push_back(cyc + 1);
            end
            mic_in = 12'($urandom);
        end
    endtask

    always @(negedge clk) begin
        if (clr) begin
            check("valid_in_reset", int'(vol_valid), 0);
            check("tick_in_reset", int'(sample_tick), 0);
        end else begin
            check("sample_tick", int'(sample_tick), int'(cyc > 0 && cyc % Div == 0));
            if (vol_valid) begin
                if (q_vol.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    check("vol", int'(vol), q_vol.pop_front());
                    check("valid_edge", cyc, q_cyc.pop_front());
                end
            end
        end
    end

    initial begin
        clr    = 1'b1;
        mic_in = 12'd4095;
        #1;
        check("reset_vol", int'(vol), 0);
        check("reset_valid", int'(vol_valid), 0);
        repeat (10) @(posedge clk);
        #3;
        mic_in = 12'd2048;
        clr    = 1'b0;

        // Silence: three windows, vol 0 at edges 33, 65, 97.
        for (int w = 0; w < 3; w++) run_samples(2048, 2048, -1, Win, 1'b1);
        // Threshold boundary and saturation.
        run_samples(640, 640, -1, Win, 1'b1);
        run_samples(3455, 3455, -1, Win, 1'b1);
        run_samples(0, 0, -1, Win, 1'b1);
        // Peak hold on sample 3, then cleared by the next window.
        run_samples(2048, 4095, 2, Win, 1'b1);
        run_samples(2048, 2048, -1, Win, 1'b1);
        // Loud sample only as the last capture of the window.
        run_samples(2048, 4095, Win - 1, Win, 1'b1);
        run_samples(2048, 2048, -1, Win, 1'b1);
        // Leave vol at 15 so the asynchronous clear is observable.
        run_samples(2048, 0, 4, Win, 1'b1);
        repeat (2) @(posedge clk);
        check("vol_before_clr", int'(vol), 15);

        // Mid-window reset after 5 loud captures.
        run_samples(4095, 4095, -1, 5, 1'b0);
        @(posedge clk);
        #2;
        clr = 1'b1;
        #1;
        check("clr_async_vol", int'(vol), 0);
        check("clr_async_valid", int'(vol_valid), 0);
        repeat (3) @(posedge clk);
        #3;
        clr = 1'b0;
        // Only post-reset samples count: peak mag 252 gives vol 1 at edge 33.
        run_samples(2048, 2300, 3, Win, 1'b1);

        for (int i = 0; i < 50 && q_vol.size() > 0; i++) @(posedge clk);
        check("scoreboard_drained", q_vol.size(), 0);
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
